// File: rtl/ep_bulk_out_if.sv
// Byte stream with valid/ready handshake, packet-end marker, keep and one user bit.
// Used for both the decoder-side input and the sink-side output of the bulk OUT end-point.
interface ep_bulk_out_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tkeep;
    logic       tuser;
    logic [7:0] tdata;

    modport master (output tvalid, tlast, tkeep, tuser, tdata, input tready);
    modport slave  (input tvalid, tlast, tkeep, tuser, tdata, output tready);
endinterface

// File: rtl/ep_bulk_out.sv
// Bulk OUT end-point: DATA0/1 sequencing, commit/rollback packet FIFO, ACK/NAK/NYET requests.
// Latency: handshake strobe 1 cycle after the s.tlast beat; committed bytes reach m 1 cycle after commit.
// Backpressure: s.tready is always 1 (no space is answered with NAK); m stream honours m.tready.
// Option EP_BULK_OUT_NYET_EN: strobe nyet_o instead of ack_o when a good packet leaves < MAX free.
module ep_bulk_out #(
    parameter int MAX_PACKET_LENGTH = 512,
    parameter int PACKET_FIFO_DEPTH = 2048,
    parameter int ENABLED           = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic set_conf_i,
    input  logic clr_conf_i,
    input  logic selected_i,
    input  logic rx_error_i,
    output logic ep_ready_o,
    output logic stalled_o,
    output logic parity_o,
    output logic ack_o,
    output logic nak_o,
    output logic nyet_o,
    ep_bulk_out_if.slave  s,
    ep_bulk_out_if.master m
);
    localparam int ABITS = $clog2(PACKET_FIFO_DEPTH);
    localparam int CBITS = $clog2(MAX_PACKET_LENGTH) + 1;
    localparam logic [ABITS:0]   DEPTH_P = (ABITS+1)'(PACKET_FIFO_DEPTH);
    localparam logic [ABITS:0]   MAX_P   = (ABITS+1)'(MAX_PACKET_LENGTH);
    localparam logic [CBITS-1:0] MAX_C   = CBITS'(MAX_PACKET_LENGTH);

    typedef enum logic [2:0] {HALT, IDLE, RECV, DROP, RESP} state_t;
    typedef enum logic [1:0] {HS_NONE, HS_ACK, HS_NAK, HS_NYET} hs_t;

    state_t           state_q, state_d;
    hs_t              hs_q, hs_d;
    logic             drop_nak_q, drop_nak_d;
    logic             par_q, par_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [ABITS:0]   wr_ptr_q, cmt_ptr_q, rd_ptr_q, rd_nxt, free;
    logic             flush, wr_en, commit, rollback, pop, m_vld;
    logic             ep_ready_q;
    logic [8:0]       mem [PACKET_FIFO_DEPTH];
    logic [8:0]       dout_q;

    assign free   = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    assign m_vld  = (rd_ptr_q != cmt_ptr_q);
    assign pop    = m_vld && m.tready;
    assign rd_nxt = flush ? '0 : rd_ptr_q + (ABITS+1)'(pop);

`ifdef EP_BULK_OUT_NYET_EN
    logic [ABITS:0] free_after;
    assign free_after = DEPTH_P - (wr_ptr_q + (ABITS+1)'(s.tkeep) - rd_ptr_q);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= HALT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        hs_d       = hs_q;
        drop_nak_d = drop_nak_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        flush      = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        case (state_q)
            HALT: ;
            IDLE: if (selected_i) begin
                cnt_d = '0;
                hs_d  = HS_NONE;
                if (free >= MAX_P) begin
                    state_d = RECV;
                end else begin
                    state_d    = DROP;
                    drop_nak_d = 1'b1;
                end
            end
            RECV: if (s.tvalid) begin
                if (s.tkeep && cnt_q == MAX_C) begin
                    // Babble: discard everything, never answer.
                    rollback   = 1'b1;
                    drop_nak_d = 1'b0;
                    hs_d       = HS_NONE;
                    state_d    = s.tlast ? RESP : DROP;
                end else begin
                    wr_en = s.tkeep;
                    cnt_d = cnt_q + CBITS'(s.tkeep);
                    if (s.tlast) begin
                        state_d = RESP;
                        if (rx_error_i) begin
                            rollback = 1'b1;
                            hs_d     = HS_NONE;
                        end else if (s.tuser != par_q) begin
                            // Host missed our ACK and resent: acknowledge, keep nothing.
                            rollback = 1'b1;
                            hs_d     = HS_ACK;
                        end else begin
                            commit = 1'b1;
                            par_d  = ~par_q;
`ifdef EP_BULK_OUT_NYET_EN
                            hs_d   = (free_after < MAX_P) ? HS_NYET : HS_ACK;
`else
                            hs_d   = HS_ACK;
`endif
                        end
                    end
                end
            end
            DROP: if (s.tvalid && s.tlast) begin
                state_d = RESP;
                hs_d    = (drop_nak_q && !rx_error_i) ? HS_NAK : HS_NONE;
            end
            RESP: state_d = IDLE;
            default: state_d = HALT;
        endcase
        if (clr_conf_i || set_conf_i) begin
            flush    = 1'b1;
            wr_en    = 1'b0;
            commit   = 1'b0;
            rollback = 1'b0;
            state_d  = clr_conf_i ? HALT : IDLE;
            if (!clr_conf_i) par_d = 1'b0;
        end
        if (ENABLED == 0) state_d = HALT;
    end

    always_comb begin
        s.tready  = 1'b1;
        stalled_o = (state_q == HALT);
        ack_o     = (state_q == RESP) && (hs_q == HS_ACK);
        nak_o     = (state_q == RESP) && (hs_q == HS_NAK);
`ifdef EP_BULK_OUT_NYET_EN
        nyet_o    = (state_q == RESP) && (hs_q == HS_NYET);
`else
        nyet_o    = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q       <= HS_NONE;
            drop_nak_q <= 1'b0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            ep_ready_q <= 1'b0;
        end else begin
            hs_q       <= hs_d;
            drop_nak_q <= drop_nak_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_nxt;
            ep_ready_q <= (state_q != HALT) && (free >= MAX_P);
            if (flush) begin
                wr_ptr_q  <= '0;
                cmt_ptr_q <= '0;
            end else begin
                if (rollback)   wr_ptr_q <= cmt_ptr_q;
                else if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (commit)     cmt_ptr_q <= wr_ptr_q + (ABITS+1)'(wr_en);
            end
        end
    end

    // Show-ahead output register; forwards a byte written into the slot about to be read.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q[ABITS-1:0]] <= {s.tlast, s.tdata};
        if (wr_en && wr_ptr_q == rd_nxt) dout_q <= {s.tlast, s.tdata};
        else                             dout_q <= mem[rd_nxt[ABITS-1:0]];
    end

    assign ep_ready_o = ep_ready_q;
    assign parity_o   = par_q;
    assign m.tvalid   = m_vld;
    assign m.tlast    = m_vld & dout_q[8];
    assign m.tdata    = dout_q[7:0];
    assign m.tkeep    = 1'b1;
    assign m.tuser    = 1'b0;
endmodule

// File: tb/tb_ep_bulk_out.sv
// Directed bench for ep_bulk_out: sequencing, error/resend handling, fill/NAK, babble, aborts.
module tb_ep_bulk_out;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic set_conf_i = 1'b0, clr_conf_i = 1'b0, selected_i = 1'b0, rx_error_i = 1'b0;
    logic ep_ready_o, stalled_o, parity_o, ack_o, nak_o, nyet_o;
    int   vec = 0;
    int   miscmp = 0;
    int   strobe_cnt = 0;
    logic [8:0] sink_q [$];

    ep_bulk_out_if s_if ();
    ep_bulk_out_if m_if ();

    ep_bulk_out #(.MAX_PACKET_LENGTH(512), .PACKET_FIFO_DEPTH(2048), .ENABLED(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .set_conf_i (set_conf_i),
        .clr_conf_i (clr_conf_i),
        .selected_i (selected_i),
        .rx_error_i (rx_error_i),
        .ep_ready_o (ep_ready_o),
        .stalled_o  (stalled_o),
        .parity_o   (parity_o),
        .ack_o      (ack_o),
        .nak_o      (nak_o),
        .nyet_o     (nyet_o),
        .s          (s_if),
        .m          (m_if)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && m_if.tvalid && m_if.tready) sink_q.push_back({m_if.tlast, m_if.tdata});
        if (ack_o || nak_o || nyet_o) strobe_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic keep,
                        input logic par, input logic err);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tkeep  = keep;
        s_if.tuser  = par;
        rx_error_i  = err & last;
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rx_error_i  = 1'b0;
    endtask

    task automatic select_ep();
        selected_i = 1'b1;
        tick();
        selected_i = 1'b0;
    endtask

    task automatic conf_pulse(input logic clr);
        if (clr) clr_conf_i = 1'b1; else set_conf_i = 1'b1;
        tick();
        clr_conf_i = 1'b0;
        set_conf_i = 1'b0;
    endtask

    // Handshake is sampled in the cycle right after the tlast beat.
    task automatic send_pkt(input int len, input logic [7:0] seed, input logic par,
                            input logic err, output logic [2:0] hs);
        logic [7:0] d;
        select_ep();
        if (len == 0) begin
            beat(8'h00, 1'b1, 1'b0, par, err);
        end else begin
            for (int i = 0; i < len; i++) begin
                d = seed + 8'(i);
                beat(d, i == len - 1, 1'b1, par, err);
            end
        end
        hs = {ack_o, nak_o, nyet_o};
        tick();
    endtask

    task automatic wait_sink(input int n);
        for (int t = 0; t < 1200 && sink_q.size() < n; t++) tick();
    endtask

    task automatic check_sink(input string name, input logic [7:0] seed);
        int errs;
        logic [8:0] exp;
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            exp = {i == 511, seed + 8'(i)};
            if (sink_q[i] !== exp) errs++;
        end
        vec++;
        if (sink_q.size() != 512 || errs != 0) begin
            miscmp++;
            $display("FAIL %s: got %0d bytes with %0d wrong, expected 512 bytes with 0 wrong",
                     name, sink_q.size(), errs);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vec++;
        if ({stalled_o, ep_ready_o, parity_o, ack_o, nak_o, nyet_o, m_if.tvalid, m_if.tlast} !== 8'b1000_0000) begin
            miscmp++;
            $display("FAIL reset_outputs: got %b expected 10000000",
                     {stalled_o, ep_ready_o, parity_o, ack_o, nak_o, nyet_o, m_if.tvalid, m_if.tlast});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_good_packet();
        logic [2:0] hs;
        conf_pulse(1'b0);
        repeat (2) tick();
        vec++;
        if ({stalled_o, ep_ready_o} !== 2'b01) begin
            miscmp++;
            $display("FAIL conf_state: got %b expected 01", {stalled_o, ep_ready_o});
        end
        m_if.tready = 1'b1;
        sink_q.delete();
        send_pkt(512, 8'h10, 1'b0, 1'b0, hs);
        vec++;
        if (hs !== 3'b100) begin miscmp++; $display("FAIL good_hs: got %b expected 100", hs); end
        vec++;
        if (parity_o !== 1'b1) begin miscmp++; $display("FAIL good_parity: got %b expected 1", parity_o); end
        wait_sink(512);
        repeat (5) tick();
        check_sink("good_sink", 8'h10);
    endtask

    task automatic test_resend();
        logic [2:0] hs;
        sink_q.delete();
        send_pkt(512, 8'h10, 1'b0, 1'b0, hs);
        vec++;
        if (hs !== 3'b100) begin miscmp++; $display("FAIL resend_hs: got %b expected 100", hs); end
        vec++;
        if (parity_o !== 1'b1) begin miscmp++; $display("FAIL resend_parity: got %b expected 1", parity_o); end
        repeat (20) tick();
        vec++;
        if (sink_q.size() != 0) begin
            miscmp++;
            $display("FAIL resend_sink: got %0d bytes expected 0", sink_q.size());
        end
    endtask

    task automatic test_error_zdp();
        logic [2:0] hs;
        int s0;
        s0 = strobe_cnt;
        send_pkt(64, 8'h20, 1'b1, 1'b1, hs);
        repeat (5) tick();
        vec++;
        if ({hs, parity_o, m_if.tvalid, ep_ready_o} !== 6'b000_101 || strobe_cnt != s0) begin
            miscmp++;
            $display("FAIL crc_error: got hs=%b par=%b mvld=%b rdy=%b strobes=%0d expected 000 1 0 1 0",
                     hs, parity_o, m_if.tvalid, ep_ready_o, strobe_cnt - s0);
        end
        send_pkt(0, 8'h00, 1'b1, 1'b0, hs);
        vec++;
        if (hs !== 3'b100) begin miscmp++; $display("FAIL zdp_hs: got %b expected 100", hs); end
        vec++;
        if (parity_o !== 1'b0) begin miscmp++; $display("FAIL zdp_parity: got %b expected 0", parity_o); end
        repeat (10) tick();
        vec++;
        if (sink_q.size() != 0) begin
            miscmp++;
            $display("FAIL zdp_sink: got %0d beats expected 0", sink_q.size());
        end
    endtask

    task automatic test_fill_nak();
        logic [2:0] hs, exp;
        m_if.tready = 1'b0;
        sink_q.delete();
        for (int k = 0; k < 4; k++) begin
            send_pkt(512, 8'h40 + 8'(16 * k), 1'(k), 1'b0, hs);
`ifdef EP_BULK_OUT_NYET_EN
            exp = (k == 3) ? 3'b001 : 3'b100;
`else
            exp = 3'b100;
`endif
            vec++;
            if (hs !== exp) begin miscmp++; $display("FAIL fill_hs_%0d: got %b expected %b", k, hs, exp); end
        end
        repeat (2) tick();
        vec++;
        if (ep_ready_o !== 1'b0) begin miscmp++; $display("FAIL full_ready: got %b expected 0", ep_ready_o); end
        send_pkt(512, 8'h80, 1'b0, 1'b0, hs);
        vec++;
        if (hs !== 3'b010) begin miscmp++; $display("FAIL full_nak: got %b expected 010", hs); end
        vec++;
        if (parity_o !== 1'b0) begin miscmp++; $display("FAIL full_parity: got %b expected 0", parity_o); end
        m_if.tready = 1'b1;
        wait_sink(512);
        m_if.tready = 1'b0;
        repeat (3) tick();
        vec++;
        if (ep_ready_o !== 1'b1) begin miscmp++; $display("FAIL drain_ready: got %b expected 1", ep_ready_o); end
        check_sink("drain_sink", 8'h40);
    endtask

    task automatic test_abort();
        logic [2:0] hs;
        int s0;
        s0 = strobe_cnt;
        send_pkt(600, 8'h90, 1'b0, 1'b0, hs);
        repeat (3) tick();
        vec++;
        if ({hs, ep_ready_o, m_if.tvalid, parity_o} !== 6'b000_110 || strobe_cnt != s0) begin
            miscmp++;
            $display("FAIL babble: got hs=%b rdy=%b mvld=%b par=%b strobes=%0d expected 000 1 1 0 0",
                     hs, ep_ready_o, m_if.tvalid, parity_o, strobe_cnt - s0);
        end
        vec++;
        if (m_if.tdata !== 8'h50) begin miscmp++; $display("FAIL babble_head: got %h expected 50", m_if.tdata); end
        select_ep();
        for (int i = 0; i < 100; i++) beat(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        conf_pulse(1'b1);
        tick();
        vec++;
        if (stalled_o !== 1'b1) begin miscmp++; $display("FAIL clr_stalled: got %b expected 1", stalled_o); end
        beat(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        vec++;
        if ({m_if.tvalid, ep_ready_o} !== 2'b00 || strobe_cnt != s0) begin
            miscmp++;
            $display("FAIL clr_abort: got mvld=%b rdy=%b strobes=%0d expected 0 0 0",
                     m_if.tvalid, ep_ready_o, strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [2:0] hs;
        conf_pulse(1'b0);
        repeat (2) tick();
        send_pkt(8, 8'hA0, 1'b0, 1'b0, hs);
        tick();
        vec++;
        if ({hs, parity_o, m_if.tvalid, m_if.tdata} !== {3'b100, 1'b1, 1'b1, 8'hA0}) begin
            miscmp++;
            $display("FAIL small_pkt: got hs=%b par=%b mvld=%b data=%h expected 100 1 1 a0",
                     hs, parity_o, m_if.tvalid, m_if.tdata);
        end
        select_ep();
        for (int i = 0; i < 50; i++) beat(8'(i), 1'b0, 1'b1, 1'b1, 1'b0);
        s_if.tvalid = 1'b1;
        reset = 1'b1;
        #2;
        vec++;
        if ({stalled_o, ep_ready_o, parity_o, ack_o, nak_o, nyet_o, m_if.tvalid, m_if.tlast} !== 8'b1000_0000) begin
            miscmp++;
            $display("FAIL midreset_outputs: got %b expected 10000000",
                     {stalled_o, ep_ready_o, parity_o, ack_o, nak_o, nyet_o, m_if.tvalid, m_if.tlast});
        end
        s_if.tvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tdata  = 8'h00;
        m_if.tready = 1'b0;
        test_reset();
        test_good_packet();
        test_resend();
        test_error_zdp();
        test_fill_nak();
        test_abort();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
